traffic_ctrl_n: RTL and testbench
=================================

# traffic_ctrl_n

Parametrised N-approach traffic-signal controller, successor to the fixed two-road (north/east) controller. It sequences GREEN → YELLOW → ALL_RED per approach and grants approaches round-robin from latched car demand. Phases are timed by configurable tick-based minimum/maximum green, yellow and all-red intervals. It sits between the sensor-conditioning logic and the lamp drivers, and emits an interval-change pulse `ic` for the monitoring logic.

## Interface
- `NUM_DIR`, 4: number of approaches, ≥2.
- `CNT_W`, 8: timer width.
- `MIN_GREEN`, 3: minimum green ticks, ≥1.
- `MAX_GREEN`, 6: maximum green ticks under competing demand, ≥`MIN_GREEN`, <2^`CNT_W`.
- `YELLOW_T`, 2: yellow ticks, ≥1.
- `ALLRED_T`, 1: all-red ticks, ≥1.
- `WALK_T`, 4: pedestrian walk ticks, ≥1 (used only with `PED_EN`).
- `clk` in 1: single clock, rising edge.
- `clr_n` in 1: asynchronous active-low reset.
- `tick` in 1: timebase enable; timers advance only when 1.
- `car_req` in `NUM_DIR`: per-approach car sensor, level.
- `ped_req` in 1: pedestrian button, level or pulse (ignored without `PED_EN`).
- `red`, `yellow`, `green` out `NUM_DIR` each: lamp drives, one-hot or zero per colour.
- `walk` out 1: walk lamp (tied 0 without `PED_EN`).
- `active_dir` out `$clog2(NUM_DIR)`: approach currently or last granted.
- `ic` out 1: one-cycle pulse in the first cycle of every new state.

## Operation
- States: ALL_RED, GREEN, YELLOW, WALK (with `PED_EN` only).
- Reset (async, immediate, also mid-phase):
  - state ALL_RED, timer 0, `active_dir` 0, pending bits 0.
  - `red` all 1; `yellow`, `green`, `walk`, `ic` 0.
- Demand latch: `pend[i]` set when `car_req[i]`=1, except for the currently green approach. `pend[i]` clears on entry to GREEN for approach i. `ped_pend` sets on `ped_req` and clears on WALK entry.
- Phase timer:
  - Cleared on every state entry; increments on `tick`, saturating at `MAX_GREEN`.
  - A T-tick state ends on the cycle where `tick`=1 and count==T-1.
- ALL_RED, on expiry:
  - If `ped_pend` is set (with `PED_EN`), go to WALK.
  - Otherwise go to GREEN for the first pending approach, searching `active_dir`+1 upward modulo `NUM_DIR`.
  - If nothing is pending, re-grant `active_dir`.
- GREEN: leaves for YELLOW on a tick where count ≥ `MIN_GREEN`-1 and competing demand exists (any other `pend` or `ped_pend`), and either `car_req[active_dir]`=0 or count ≥ `MAX_GREEN`-1.
- GREEN with no competing demand: rests indefinitely.
- YELLOW: `YELLOW_T` ticks, then ALL_RED.
- WALK: all `red`=1, `walk`=1 for `WALK_T` ticks, then ALL_RED for another `ALLRED_T` ticks before the next grant.
- Outputs decode from registered state and `active_dir`:
  - `red[i]`=1 unless approach i is in GREEN or YELLOW.
  - At most one approach is non-red at any time.
- A request arriving in the same cycle as a grant decision is latched and served in a later phase.

## Timing
- Outputs are registered; lamps change one cycle after the expiring tick.
- `ic` is high exactly in the first cycle of each state.
- With `tick`=1, the minimum serve sequence is `MIN_GREEN`+`YELLOW_T`+`ALLRED_T` cycles between two grants.
- `tick`=0 freezes timers; demand still latches.

## Configuration
- `TRAFFIC_PED_EN` defined: `ped_req`, `ped_pend` and the WALK state exist; pending pedestrians count as competing demand.
- Undefined: WALK logic is removed, `walk` is tied 0, and `ped_req` is ignored.

## Structure
- Shared package `traffic_pkg`:
  - state enum `tl_state_t` (ALL_RED, GREEN, YELLOW, WALK);
  - the round-robin search function.
- Sub-module `phase_timer`: CNT_W counter with clear, tick enable, saturation and an expire compare.

## Test plan
Parameters are defaults, `tick`=1.
- Reset, no requests: `red`=1111 during reset; `green`=0001 on the 2nd cycle after release with `ic` pulsed once; remains green.
- Dir0 green, `car_req`=0100 pulse, `car_req[0]`=0: yellow[0] after 3 green cycles, then 2 yellow, 1 all-red; `green`=0100, `active_dir`=2.
- `car_req[0]` held 1, `car_req[1]` pulsed: dir0 green for exactly 6 cycles, then yellow; next grant dir1.
- `active_dir`=2, `pend`=1010: grants dir3, then dir1 (wrap).
- `TRAFFIC_PED_EN`, `ped_req` pulse during dir0 green: yellow, all-red, `walk`=1 for 4 cycles, all-red 1, then green 0001 (re-grant).
- `clr_n` low mid-yellow: `red`=1111 and `yellow`=0000 before the next edge; pending bits cleared; `tick`=0 for 10 cycles after release holds ALL_RED.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding and round-robin grant search for traffic_ctrl_n
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    WALK    = 2'd3
  } tl_state_t;

  localparam int RR_MAX = 32;

  // First set bit of pend searching cur+1 upward, wrapping at n; cur itself is
  // checked last. Returns -1 when nothing is pending.
  function automatic int rr_search(input logic [RR_MAX-1:0] pend, input int cur, input int n);
    int idx;
    int res;
    res = -1;
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = cur + k;
        if (idx >= n) idx = idx - n;
        if (pend[idx[4:0]]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/traffic_ctrl_n_phase_timer.sv
// rtl/traffic_ctrl_n_phase_timer.sv - tick-enabled saturating phase counter with expire compare
module phase_timer #(
  parameter int CNT_W = 8,
  parameter int SAT   = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over tick so every new state starts from zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && (count_q < SAT_V)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = tick && (count_q == limit);

endmodule

// File: rtl/traffic_ctrl_n.sv
// rtl/traffic_ctrl_n.sv - N-approach round-robin traffic controller; optional WALK phase under TRAFFIC_PED_EN
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int NUM_DIR   = 4,
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 3,
  parameter int MAX_GREEN = 6,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 4
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       tick,
  input  logic [NUM_DIR-1:0]         car_req,
  input  logic                       ped_req,
  output logic [NUM_DIR-1:0]         red,
  output logic [NUM_DIR-1:0]         yellow,
  output logic [NUM_DIR-1:0]         green,
  output logic                       walk,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic                       ic
);

  localparam int DIR_W = $clog2(NUM_DIR);
  // Saturate high enough that every fixed interval can still reach its expire count.
  localparam int SAT_GY = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
  localparam int SAT_AW = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
  localparam int SAT    = (SAT_GY > SAT_AW) ? SAT_GY : SAT_AW;
  localparam logic [CNT_W-1:0] MING_V = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAXG_V = CNT_W'(MAX_GREEN - 1);

  tl_state_t          state_q, state_d;
  logic [DIR_W-1:0]   active_q, active_d;
  logic [NUM_DIR-1:0] pend_q, pend_d;
  logic               ic_q, ic_d;
  logic               state_change, grant, expire, competing, ped_pend;
  logic [CNT_W-1:0]   count, limit;
  logic [NUM_DIR-1:0] dir_onehot, green_mask;
  int                 rr_idx;

`ifdef TRAFFIC_PED_EN
  logic ped_pend_q, ped_pend_d;
  assign ped_pend = ped_pend_q;
  assign walk     = (state_q == WALK);

  // Pedestrian demand latch, consumed on entry to WALK.
  always_comb begin
    ped_pend_d = ped_pend_q | ped_req;
    if (state_change && (state_d == WALK)) ped_pend_d = 1'b0;
  end

  // Pedestrian demand register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) ped_pend_q <= 1'b0;
    else        ped_pend_q <= ped_pend_d;
  end
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign ped_pend   = 1'b0;
  assign walk       = 1'b0;
`endif

  assign dir_onehot   = NUM_DIR'(1) << active_q;
  assign green_mask   = (state_q == GREEN) ? dir_onehot : '0;
  assign competing    = (|(pend_q & ~dir_onehot)) | ped_pend;
  assign rr_idx       = rr_search(RR_MAX'(pend_q), int'(active_q), NUM_DIR);
  assign state_change = (state_d != state_q);

  phase_timer #(.CNT_W(CNT_W), .SAT(SAT)) u_timer (
    .clk    (clk),
    .clr_n  (clr_n),
    .clear  (state_change),
    .tick   (tick),
    .limit  (limit),
    .count  (count),
    .expire (expire)
  );

  // Next-state, grant selection and per-state interval length.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    grant    = 1'b0;
    limit    = CNT_W'(ALLRED_T - 1);
    case (state_q)
      ALL_RED: begin
        if (expire) begin
          if (ped_pend) begin
            state_d = WALK;
          end else begin
            state_d = GREEN;
            grant   = 1'b1;
            if (rr_idx >= 0) active_d = DIR_W'(rr_idx);
          end
        end
      end
      GREEN: begin
        if (tick && (count >= MING_V) && competing &&
            (!car_req[active_q] || (count >= MAXG_V))) begin
          state_d = YELLOW;
        end
      end
      YELLOW: begin
        limit = CNT_W'(YELLOW_T - 1);
        if (expire) state_d = ALL_RED;
      end
`ifdef TRAFFIC_PED_EN
      WALK: begin
        limit = CNT_W'(WALK_T - 1);
        if (expire) state_d = ALL_RED;
      end
`endif
      default: state_d = ALL_RED;
    endcase
  end

  // Car demand latch; the granted approach is cleared even if it requests in the same cycle.
  always_comb begin
    pend_d = pend_q | (car_req & ~green_mask);
    if (grant) pend_d = pend_d & ~(NUM_DIR'(1) << active_d);
    ic_d = state_change;
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= ALL_RED;
      active_q <= '0;
      pend_q   <= '0;
      ic_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      ic_q     <= ic_d;
    end
  end

  // Lamp decode: only the active approach may leave red, and only in GREEN or YELLOW.
  always_comb begin
    red    = '1;
    yellow = '0;
    green  = '0;
    if (state_q == GREEN) begin
      green = dir_onehot;
      red   = ~dir_onehot;
    end else if (state_q == YELLOW) begin
      yellow = dir_onehot;
      red    = ~dir_onehot;
    end
  end

  assign active_dir = active_q;
  assign ic         = ic_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// tb/tb_traffic_ctrl_n.sv - scoreboard bench for traffic_ctrl_n (WALK scenario under TRAFFIC_PED_EN)
module tb_traffic_ctrl_n;

  logic       clk = 1'b0;
  logic       clr_n, tick, ped_req;
  logic [3:0] car_req;
  logic [3:0] red, yellow, green;
  logic       walk, ic;
  logic [1:0] active_dir;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  traffic_ctrl_n dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .tick       (tick),
    .car_req    (car_req),
    .ped_req    (ped_req),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .walk       (walk),
    .active_dir (active_dir),
    .ic         (ic)
  );

  task automatic push(input string nm, input logic i, input logic w,
                      input logic [3:0] y, input logic [3:0] g, input logic [1:0] a);
    exp_t e;
    e.name = nm;
    e.v    = {i, w, ~(y | g), y, g, a};
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_release();
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    push("rst", 0, 0, 4'h0, 4'h0, 0);
    push("rst", 0, 0, 4'h0, 4'h0, 0);
    push("rst", 1, 0, 4'h0, 4'b0001, 0);
    repeat (3) push("rst", 0, 0, 4'h0, 4'b0001, 0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_t e;
      logic [15:0] got;
      step();
      e   = sb.pop_front();
      got = {ic, walk, red, yellow, green, active_dir};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s[%0d] got=0x%04h required=0x%04h", e.name, k, got, e.v);
      end
      if (k == 1) clr_n = 1'b1;
    end
  endtask

  task automatic test_round_robin();
    reset_release();
    push("rr", 1, 0, 4'h0, 4'b0001, 0);
    repeat (2) push("rr", 0, 0, 4'h0, 4'b0001, 0);
    push("rr", 1, 0, 4'b0001, 4'h0, 0);
    push("rr", 0, 0, 4'b0001, 4'h0, 0);
    push("rr", 1, 0, 4'h0, 4'h0, 0);
    push("rr", 1, 0, 4'h0, 4'b0100, 2);
    repeat (2) push("rr", 0, 0, 4'h0, 4'b0100, 2);
    push("rr", 1, 0, 4'b0100, 4'h0, 2);
    push("rr", 0, 0, 4'b0100, 4'h0, 2);
    push("rr", 1, 0, 4'h0, 4'h0, 2);
    push("rr", 1, 0, 4'h0, 4'b1000, 3);
    repeat (2) push("rr", 0, 0, 4'h0, 4'b1000, 3);
    push("rr", 1, 0, 4'b1000, 4'h0, 3);
    push("rr", 0, 0, 4'b1000, 4'h0, 3);
    push("rr", 1, 0, 4'h0, 4'h0, 3);
    push("rr", 1, 0, 4'h0, 4'b0010, 1);
    repeat (2) push("rr", 0, 0, 4'h0, 4'b0010, 1);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_t e;
      logic [15:0] got;
      step();
      e   = sb.pop_front();
      got = {ic, walk, red, yellow, green, active_dir};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s[%0d] got=0x%04h required=0x%04h", e.name, k, got, e.v);
      end
      if (k == 0) car_req = 4'b0100;
      if (k == 1) car_req = 4'b0000;
      if (k == 6) car_req = 4'b1010;
      if (k == 7) car_req = 4'b0000;
    end
  endtask

  task automatic test_max_green();
    reset_release();
    push("maxg", 1, 0, 4'h0, 4'b0001, 0);
    repeat (5) push("maxg", 0, 0, 4'h0, 4'b0001, 0);
    push("maxg", 1, 0, 4'b0001, 4'h0, 0);
    push("maxg", 0, 0, 4'b0001, 4'h0, 0);
    push("maxg", 1, 0, 4'h0, 4'h0, 0);
    push("maxg", 1, 0, 4'h0, 4'b0010, 1);
    repeat (2) push("maxg", 0, 0, 4'h0, 4'b0010, 1);
    push("maxg", 1, 0, 4'b0010, 4'h0, 1);
    push("maxg", 0, 0, 4'b0010, 4'h0, 1);
    push("maxg", 1, 0, 4'h0, 4'h0, 1);
    push("maxg", 1, 0, 4'h0, 4'b0001, 0);
    push("maxg", 0, 0, 4'h0, 4'b0001, 0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_t e;
      logic [15:0] got;
      step();
      e   = sb.pop_front();
      got = {ic, walk, red, yellow, green, active_dir};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s[%0d] got=0x%04h required=0x%04h", e.name, k, got, e.v);
      end
      if (k == 0) car_req = 4'b0011;
      if (k == 1) car_req = 4'b0001;
    end
    car_req = 4'b0000;
  endtask

  task automatic test_ped();
`ifdef TRAFFIC_PED_EN
    reset_release();
    push("ped", 1, 0, 4'h0, 4'b0001, 0);
    repeat (2) push("ped", 0, 0, 4'h0, 4'b0001, 0);
    push("ped", 1, 0, 4'b0001, 4'h0, 0);
    push("ped", 0, 0, 4'b0001, 4'h0, 0);
    push("ped", 1, 0, 4'h0, 4'h0, 0);
    push("ped", 1, 1, 4'h0, 4'h0, 0);
    repeat (3) push("ped", 0, 1, 4'h0, 4'h0, 0);
    push("ped", 1, 0, 4'h0, 4'h0, 0);
    push("ped", 1, 0, 4'h0, 4'b0001, 0);
    push("ped", 0, 0, 4'h0, 4'b0001, 0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_t e;
      logic [15:0] got;
      step();
      e   = sb.pop_front();
      got = {ic, walk, red, yellow, green, active_dir};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s[%0d] got=0x%04h required=0x%04h", e.name, k, got, e.v);
      end
      if (k == 0) ped_req = 1'b1;
      if (k == 1) ped_req = 1'b0;
    end
`endif
  endtask

  task automatic test_reset_mid_yellow();
    reset_release();
    push("midy", 1, 0, 4'h0, 4'b0001, 0);
    repeat (2) push("midy", 0, 0, 4'h0, 4'b0001, 0);
    push("midy", 1, 0, 4'b0001, 4'h0, 0);
    push("midy", 0, 0, 4'b0001, 4'h0, 0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_t e;
      logic [15:0] got;
      step();
      e   = sb.pop_front();
      got = {ic, walk, red, yellow, green, active_dir};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s[%0d] got=0x%04h required=0x%04h", e.name, k, got, e.v);
      end
      if (k == 0) car_req = 4'b0100;
      if (k == 1) car_req = 4'b0000;
      if (k == 3) car_req = 4'b0010;
    end
    clr_n   = 1'b0;
    car_req = 4'b0000;
    #1;
    checks++;
    if ({red, yellow, green} !== 12'hF00) begin
      errors++;
      $display("FAIL async_clear got=0x%03h required=0x%03h", {red, yellow, green}, 12'hF00);
    end
    repeat (11) push("hold", 0, 0, 4'h0, 4'h0, 0);
    push("hold", 1, 0, 4'h0, 4'b0001, 0);
    push("hold", 0, 0, 4'h0, 4'b0001, 0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_t e;
      logic [15:0] got;
      step();
      e   = sb.pop_front();
      got = {ic, walk, red, yellow, green, active_dir};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s[%0d] got=0x%04h required=0x%04h", e.name, k, got, e.v);
      end
      if (k == 0) begin
        clr_n = 1'b1;
        tick  = 1'b0;
      end
      if (k == 10) tick = 1'b1;
    end
  endtask

  initial begin
    clr_n   = 1'b1;
    tick    = 1'b1;
    car_req = 4'b0000;
    ped_req = 1'b0;
    #3;
    clr_n = 1'b0;
    test_reset();
    test_round_robin();
    test_max_green();
    test_ped();
    test_reset_mid_yellow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
